mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbiter and sequencer for the single unified memory port of the multicycle MIPS core. Two requesters share it: the CPU control path (instruction fetch and LW/SW data, selected upstream by IorD) and the program loader/debug port. The block serialises their transactions, drives the memory for a fixed read latency and returns data with a one-cycle acknowledge. It produces a stall signal that freezes the control unit's state while a CPU access is pending.

## Interface
- `AW`, 32: address width.
- `DW`, 32: data width.
- `MEM_LAT`, 2: memory read latency in cycles; minimum 1, maximum 15.

- `Clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `cpu_req`  in  1  CPU transaction request.
- `cpu_we`  in  1  1 = write (SW), 0 = read (fetch/LW).
- `cpu_addr`  in  AW  CPU address.
- `cpu_wdata`  in  DW  CPU write data.
- `cpu_ack`  out  1  one-cycle completion pulse.
- `cpu_stall`  out  1  equals `cpu_req & ~cpu_ack`.
- `ldr_req`, `ldr_we`, `ldr_addr`, `ldr_wdata`, `ldr_ack`: loader equivalents of the CPU signals, same widths.
- `rd_data`  out  DW  read data; valid in the cycle an ack is high.
- `mem_en`  out  1  memory access strobe, one cycle per transaction.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  AW  memory address.
- `mem_wdata`  out  DW  memory write data.
- `mem_rdata`  in  DW  valid `MEM_LAT` cycles after the `mem_en` cycle.

## Operation
- **FSM states:** IDLE, ACCESS, WAIT, RESP.
- **IDLE:** if any request is present, the arbitration winner is latched into `gnt`, together with its we, addr and wdata. Next state is ACCESS. With no request, the FSM stays in IDLE.
- **ACCESS:** `mem_en` = 1 and the latched `mem_we`, `mem_addr`, `mem_wdata` are driven. The latency counter is loaded with `MEM_LAT`. Next state is WAIT.
- **WAIT:** the counter decrements each cycle. When it reaches 1, `mem_rdata` is captured into the `rd_data` register. Writes also wait the full latency. Next state is RESP.
- **RESP:** exactly the ack of the granted port is 1. Next state is IDLE.
- **Request handshake:**
  - A requester holds req, we, addr and wdata stable from assertion until its ack.
  - Keeping req high after ack requests a new transaction. The new request is sampled in the following IDLE cycle.
  - Dropping req before ack is illegal. The transaction still completes and acks.
- **Arbitration:** applied only in IDLE. A lone requester always wins.
- **Outputs outside ACCESS:** `mem_en` = 0 and `mem_we` = 0. `mem_addr` and `mem_wdata` hold their last latched values.
- **Reset:** asynchronous reset forces the following, at any state including mid-transaction:
  - state goes to IDLE;
  - `cpu_ack`, `ldr_ack`, `mem_en`, `mem_we` = 0;
  - `rd_data`, `mem_addr`, `mem_wdata` = 0;
  - counter = 0;
  - last grant = loader.
- **Lost transactions:** an interrupted transaction is lost and no ack is issued. A write already strobed is not undone.

## Timing
- **Latency:** request sampled in IDLE at cycle t gives:
  - `mem_en` at t+1;
  - data valid at t+1+`MEM_LAT`;
  - ack at t+2+`MEM_LAT`.
  - With `MEM_LAT` = 2, ack is 4 cycles after the request.
- **Throughput:** one transaction per `MEM_LAT`+3 cycles under continuous demand.
- **`cpu_stall`:** combinational and high from req until the ack cycle inclusive-exclusive (low in the ack cycle).
- **Registered outputs:** `rd_data` and the acks are registered.

## Configuration
- **Macro `MEM_ARB_RR_EN`:**
  - **Defined:** round-robin arbitration. On simultaneous requests the port not granted last wins, and the last grant updates at every IDLE→ACCESS transition. After reset the CPU wins the first tie.
  - **Undefined:** fixed priority with the CPU always winning ties. The loader can starve while the CPU runs, which is acceptable because the loader operates with the core held in reset.

## Structure
- **Shared package `mem_arb_pkg`:**
  - state encoding (IDLE=2'd0, ACCESS=2'd1, WAIT=2'd2, RESP=2'd3);
  - port index constants `PORT_CPU`=0 and `PORT_LDR`=1.
- **Sub-module `mem_arb_sel`:** one combinational/registered grant selector holding the last-grant flop and the RR/fixed-priority logic. The FSM, counter and data path stay in the top module.

## Test plan
- **CPU read:** `MEM_LAT`=2, `cpu_req` with addr 0x10, memory returns 0xDEADBEEF → `mem_en` at t+1 with `mem_addr` 0x10; `cpu_ack` at t+4; `rd_data` 0xDEADBEEF; `cpu_stall` high for t..t+3.
- **Loader write:** addr 0x40, data 0x12345678 → single `mem_en` cycle with `mem_we`=1 and those values; `ldr_ack` at t+4; `cpu_ack` stays 0.
- **Simultaneous requests, `MEM_ARB_RR_EN` defined, both held:** grants alternate CPU, LDR, CPU, LDR with acks every 5 cycles. Without the macro, four consecutive CPU grants and `ldr_ack` never asserts.
- **Back-to-back CPU reads, req held across ack:** addrs 0x0 then 0x4 → second `mem_en` exactly 2 cycles after the first ack; both acks are one cycle wide.
- **Reset in WAIT:** reset asserted mid-transaction → outputs 0 asynchronously, no ack; after release a new request completes normally in `MEM_LAT`+2 cycles.
- **Latency sweep:** `MEM_LAT`=1 and 15 → ack at t+3 and t+17 respectively; data captured matches memory model.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } arb_state_e;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LDR = 1'b1;

endpackage

// File: rtl/mem_arb_sel.sv
// Grant selector for the memory port: holds the last-grant flop.
// MEM_ARB_RR_EN selects round-robin on ties; otherwise the CPU always wins ties.
module mem_arb_sel
    import mem_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic cpu_req,
    input  logic ldr_req,
    input  logic take,
    output logic gnt
);

    logic last_gnt_q, last_gnt_d;

    // With no request the grant is irrelevant, so the last grant is reused.
    always_comb begin
        gnt = last_gnt_q;
        if (cpu_req && ldr_req) begin
`ifdef MEM_ARB_RR_EN
            gnt = (last_gnt_q == PORT_CPU) ? PORT_LDR : PORT_CPU;
`else
            gnt = PORT_CPU;
`endif
        end else if (cpu_req) begin
            gnt = PORT_CPU;
        end else if (ldr_req) begin
            gnt = PORT_LDR;
        end
    end

    always_comb begin
        last_gnt_d = take ? gnt : last_gnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt_q <= PORT_LDR;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter/sequencer for the multicycle MIPS core's single memory port (CPU + loader).
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed CPU priority.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 2
) (
    input  logic          Clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic          cpu_stall,
    input  logic          ldr_req,
    input  logic          ldr_we,
    input  logic [AW-1:0] ldr_addr,
    input  logic [DW-1:0] ldr_wdata,
    output logic          ldr_ack,
    output logic [DW-1:0] rd_data,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT);

    arb_state_e    state_q, state_d;
    logic          gnt_q, gnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [DW-1:0] rd_data_q, rd_data_d;
    logic          cpu_ack_q, cpu_ack_d;
    logic          ldr_ack_q, ldr_ack_d;
    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic          sel_gnt;
    logic          take;

    mem_arb_sel u_sel (
        .clk     (Clk),
        .rst     (reset),
        .cpu_req (cpu_req),
        .ldr_req (ldr_req),
        .take    (take),
        .gnt     (sel_gnt)
    );

    // Strobe and acks are computed one state early so they are registered outputs.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        rd_data_d = rd_data_q;
        cpu_ack_d = 1'b0;
        ldr_ack_d = 1'b0;
        mem_en_d  = 1'b0;
        mem_we_d  = 1'b0;
        take      = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_req || ldr_req) begin
                    take     = 1'b1;
                    gnt_d    = sel_gnt;
                    mem_en_d = 1'b1;
                    state_d  = ACCESS;
                    if (sel_gnt == PORT_LDR) begin
                        addr_d   = ldr_addr;
                        wdata_d  = ldr_wdata;
                        mem_we_d = ldr_we;
                    end else begin
                        addr_d   = cpu_addr;
                        wdata_d  = cpu_wdata;
                        mem_we_d = cpu_we;
                    end
                end
            end
            ACCESS: begin
                cnt_d   = LAT_LOAD;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    rd_data_d = mem_rdata;
                    cpu_ack_d = (gnt_q == PORT_CPU);
                    ldr_ack_d = (gnt_q == PORT_LDR);
                    state_d   = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            gnt_q     <= PORT_CPU;
            addr_q    <= '0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            rd_data_q <= '0;
            cpu_ack_q <= 1'b0;
            ldr_ack_q <= 1'b0;
            mem_en_q  <= 1'b0;
            mem_we_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            rd_data_q <= rd_data_d;
            cpu_ack_q <= cpu_ack_d;
            ldr_ack_q <= ldr_ack_d;
            mem_en_q  <= mem_en_d;
            mem_we_q  <= mem_we_d;
        end
    end

    assign cpu_ack   = cpu_ack_q;
    assign ldr_ack   = ldr_ack_q;
    assign cpu_stall = cpu_req & ~cpu_ack_q;
    assign rd_data   = rd_data_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: transaction-level model plus directed cases.
// Expectations follow MEM_ARB_RR_EN the same way the design does.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int LAT = 2;

    logic        Clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, ldr_req, ldr_we;
    logic [31:0] cpu_addr, cpu_wdata, ldr_addr, ldr_wdata;
    logic        cpu_ack, cpu_stall, ldr_ack, mem_en, mem_we;
    logic [31:0] rd_data, mem_addr, mem_wdata, mem_rdata;
    logic        chk_on;

    int tests_run = 0;
    int tests_failed = 0;

    initial forever #5 Clk = ~Clk;

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT)) dut (
        .Clk(Clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_ack(ldr_ack), .rd_data(rd_data),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Two extra instances cover the latency extremes with a read-only memory.
    logic        sw_req [2];
    logic [31:0] sw_addr [2];
    logic        sw_ack [2], sw_stall [2], sw_ldr_ack [2], sw_en [2], sw_we [2];
    logic [31:0] sw_rd [2], sw_addr_o [2], sw_wdata_o [2], sw_rdata [2];
    logic [31:0] sw_pipe0 [0:15];
    logic [31:0] sw_pipe1 [0:15];

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) u_lat1 (
        .Clk(Clk), .reset(reset),
        .cpu_req(sw_req[0]), .cpu_we(1'b0), .cpu_addr(sw_addr[0]), .cpu_wdata(32'h0),
        .cpu_ack(sw_ack[0]), .cpu_stall(sw_stall[0]),
        .ldr_req(1'b0), .ldr_we(1'b0), .ldr_addr(32'h0), .ldr_wdata(32'h0),
        .ldr_ack(sw_ldr_ack[0]), .rd_data(sw_rd[0]),
        .mem_en(sw_en[0]), .mem_we(sw_we[0]), .mem_addr(sw_addr_o[0]), .mem_wdata(sw_wdata_o[0]),
        .mem_rdata(sw_rdata[0])
    );

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(15)) u_lat15 (
        .Clk(Clk), .reset(reset),
        .cpu_req(sw_req[1]), .cpu_we(1'b0), .cpu_addr(sw_addr[1]), .cpu_wdata(32'h0),
        .cpu_ack(sw_ack[1]), .cpu_stall(sw_stall[1]),
        .ldr_req(1'b0), .ldr_we(1'b0), .ldr_addr(32'h0), .ldr_wdata(32'h0),
        .ldr_ack(sw_ldr_ack[1]), .rd_data(sw_rd[1]),
        .mem_en(sw_en[1]), .mem_we(sw_we[1]), .mem_addr(sw_addr_o[1]), .mem_wdata(sw_wdata_o[1]),
        .mem_rdata(sw_rdata[1])
    );

    function automatic logic [31:0] dflt(input logic [31:0] a);
        if (a == 32'h10) return 32'hDEADBEEF;
        return {a[15:0], ~a[15:0]};
    endfunction

    // Memory seen by the DUT: data appears exactly LAT cycles after the strobe, noise otherwise.
    logic [31:0] env_mem [0:255];
    bit          env_valid [0:255];
    logic [31:0] pipe_m [0:15];

    always @(posedge Clk) begin
        for (int i = 15; i > 0; i--) begin
            pipe_m[i]   <= pipe_m[i-1];
            sw_pipe0[i] <= sw_pipe0[i-1];
            sw_pipe1[i] <= sw_pipe1[i-1];
        end
        if (mem_en) begin
            pipe_m[0] <= env_valid[mem_addr[9:2]] ? env_mem[mem_addr[9:2]] : dflt(mem_addr);
            if (mem_we) begin
                env_mem[mem_addr[9:2]]   <= mem_wdata;
                env_valid[mem_addr[9:2]] <= 1'b1;
            end
        end else begin
            pipe_m[0] <= $urandom;
        end
        sw_pipe0[0] <= sw_en[0] ? dflt(sw_addr_o[0]) : $urandom;
        sw_pipe1[0] <= sw_en[1] ? dflt(sw_addr_o[1]) : $urandom;
    end

    assign mem_rdata   = pipe_m[LAT-1];
    assign sw_rdata[0] = sw_pipe0[0];
    assign sw_rdata[1] = sw_pipe1[14];

    // Reference model: a transaction granted at cycle t strobes at t+1 and acks at t+LAT+2.
    bit          m_busy;
    int          m_k;
    logic        m_port, m_we, m_last;
    logic [31:0] m_addr, m_wdata, m_rd;
    logic [31:0] ref_mem [0:255];
    bit          ref_valid [0:255];

    initial begin : model_proc
        logic win;
        m_busy = 0; m_k = 0; m_port = PORT_CPU; m_we = 0; m_last = PORT_LDR;
        m_addr = 0; m_wdata = 0; m_rd = 0;
        forever begin
            @(posedge Clk or posedge reset);
            if (reset) begin
                m_busy = 0; m_k = 0; m_last = PORT_LDR; m_addr = 0; m_wdata = 0; m_rd = 0;
            end else if (m_busy) begin
                if (m_k == LAT + 2) begin
                    m_busy = 0;
                    m_k = 0;
                end else begin
                    m_k++;
                end
            end else if (cpu_req || ldr_req) begin
                if (cpu_req && ldr_req) begin
`ifdef MEM_ARB_RR_EN
                    win = (m_last == PORT_CPU) ? PORT_LDR : PORT_CPU;
`else
                    win = PORT_CPU;
`endif
                end else begin
                    win = ldr_req ? PORT_LDR : PORT_CPU;
                end
                m_last  = win;
                m_port  = win;
                m_we    = (win == PORT_LDR) ? ldr_we : cpu_we;
                m_addr  = (win == PORT_LDR) ? ldr_addr : cpu_addr;
                m_wdata = (win == PORT_LDR) ? ldr_wdata : cpu_wdata;
                if (m_we) begin
                    ref_mem[m_addr[9:2]]   = m_wdata;
                    ref_valid[m_addr[9:2]] = 1'b1;
                end else begin
                    m_rd = ref_valid[m_addr[9:2]] ? ref_mem[m_addr[9:2]] : dflt(m_addr);
                end
                m_busy = 1;
                m_k = 1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    initial begin : compare_proc
        logic e_en, e_cack, e_lack;
        forever begin
            @(negedge Clk);
            if (chk_on && !reset) begin
                e_en   = m_busy && (m_k == 1);
                e_cack = m_busy && (m_k == LAT + 2) && (m_port == PORT_CPU);
                e_lack = m_busy && (m_k == LAT + 2) && (m_port == PORT_LDR);
                checkOutput("mem_en", 32'(mem_en), 32'(e_en));
                checkOutput("mem_we", 32'(mem_we), 32'(e_en && m_we));
                checkOutput("mem_addr", mem_addr, m_addr);
                checkOutput("mem_wdata", mem_wdata, m_wdata);
                checkOutput("cpu_ack", 32'(cpu_ack), 32'(e_cack));
                checkOutput("ldr_ack", 32'(ldr_ack), 32'(e_lack));
                checkOutput("cpu_stall", 32'(cpu_stall), 32'(cpu_req && !e_cack));
                if ((e_cack || e_lack) && !m_we) checkOutput("rd_data", rd_data, m_rd);
            end
        end
    end

    task automatic nextDrive();
        @(negedge Clk);
        #1;
    endtask

    task automatic applyStimulus(input logic port, input logic req, input logic we,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        if (port == PORT_LDR) begin
            ldr_req = req; ldr_we = we; ldr_addr = addr; ldr_wdata = wdata;
        end else begin
            cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        end
    endtask

    task automatic settle();
        repeat (8) @(negedge Clk);
    endtask

    task automatic pulseReset();
        @(negedge Clk);
        #2 reset = 1'b1;
        repeat (2) @(negedge Clk);
        #2 reset = 1'b0;
    endtask

    task automatic testCpuRead();
        int ack_at = -1;
        int en_cnt = 0;
        nextDrive();
        applyStimulus(PORT_CPU, 1'b1, 1'b0, 32'h10, 32'h0);
        #1 checkOutput("read_stall_t0", 32'(cpu_stall), 1);
        for (int k = 1; k <= 6; k++) begin
            @(negedge Clk);
            if (k == 1) begin
                checkOutput("read_en_t1", 32'(mem_en), 1);
                checkOutput("read_addr_t1", mem_addr, 32'h10);
            end
            if (k <= 3) checkOutput("read_stall_hold", 32'(cpu_stall), 1);
            en_cnt += int'(mem_en);
            if (cpu_ack && ack_at < 0) begin
                ack_at = k;
                checkOutput("read_data", rd_data, 32'hDEADBEEF);
                checkOutput("read_stall_ack", 32'(cpu_stall), 0);
                #1 cpu_req = 1'b0;
            end
        end
        cpu_req = 1'b0;
        checkOutput("read_ack_cycle", 32'(ack_at), 4);
        checkOutput("read_en_count", 32'(en_cnt), 1);
    endtask

    task automatic testLdrWrite();
        int ack_at = -1;
        int en_cnt = 0;
        int cpu_acks = 0;
        nextDrive();
        applyStimulus(PORT_LDR, 1'b1, 1'b1, 32'h40, 32'h12345678);
        for (int k = 1; k <= 6; k++) begin
            @(negedge Clk);
            if (k == 1) begin
                checkOutput("wr_en_t1", 32'(mem_en), 1);
                checkOutput("wr_we_t1", 32'(mem_we), 1);
                checkOutput("wr_addr_t1", mem_addr, 32'h40);
                checkOutput("wr_data_t1", mem_wdata, 32'h12345678);
            end
            en_cnt += int'(mem_en);
            cpu_acks += int'(cpu_ack);
            if (ldr_ack && ack_at < 0) begin
                ack_at = k;
                #1 ldr_req = 1'b0;
            end
        end
        ldr_req = 1'b0;
        checkOutput("wr_ack_cycle", 32'(ack_at), 4);
        checkOutput("wr_en_count", 32'(en_cnt), 1);
        checkOutput("wr_no_cpu_ack", 32'(cpu_acks), 0);
    endtask

    task automatic testBackToBack();
        int acks[$];
        int ens[$];
        logic [31:0] en_addr[$];
        nextDrive();
        applyStimulus(PORT_CPU, 1'b1, 1'b0, 32'h0, 32'h0);
        for (int k = 1; k <= 15; k++) begin
            @(negedge Clk);
            if (mem_en) begin
                ens.push_back(k);
                en_addr.push_back(mem_addr);
            end
            if (cpu_ack) begin
                acks.push_back(k);
                #1;
                if (acks.size() == 1) cpu_addr = 32'h4;
                else cpu_req = 1'b0;
            end
        end
        cpu_req = 1'b0;
        checkOutput("b2b_ack_count", 32'(acks.size()), 2);
        checkOutput("b2b_en_count", 32'(ens.size()), 2);
        if (acks.size() == 2) begin
            checkOutput("b2b_ack0", 32'(acks[0]), 4);
            checkOutput("b2b_ack1", 32'(acks[1]), 9);
        end
        if (ens.size() == 2 && acks.size() >= 1) begin
            checkOutput("b2b_en_gap", 32'(ens[1] - acks[0]), 2);
            checkOutput("b2b_addr2", en_addr[1], 32'h4);
        end
    endtask

    task automatic testSimultaneous();
        int ack_k[$];
        logic ack_p[$];
        int lacks = 0;
        logic exp_p [4];
`ifdef MEM_ARB_RR_EN
        exp_p = '{PORT_CPU, PORT_LDR, PORT_CPU, PORT_LDR};
`else
        exp_p = '{PORT_CPU, PORT_CPU, PORT_CPU, PORT_CPU};
`endif
        nextDrive();
        applyStimulus(PORT_CPU, 1'b1, 1'b0, 32'h100, 32'h0);
        applyStimulus(PORT_LDR, 1'b1, 1'b0, 32'h200, 32'h0);
        for (int k = 1; k <= 30 && ack_k.size() < 4; k++) begin
            @(negedge Clk);
            lacks += int'(ldr_ack);
            if (cpu_ack || ldr_ack) begin
                ack_k.push_back(k);
                ack_p.push_back(ldr_ack);
            end
        end
        #1;
        cpu_req = 1'b0;
        ldr_req = 1'b0;
        checkOutput("sim_ack_count", 32'(ack_k.size()), 4);
        if (ack_k.size() == 4) begin
            checkOutput("sim_first_ack", 32'(ack_k[0]), 4);
            for (int i = 0; i < 4; i++) begin
                checkOutput("sim_grant_order", 32'(ack_p[i]), 32'(exp_p[i]));
                if (i > 0) checkOutput("sim_ack_gap", 32'(ack_k[i] - ack_k[i-1]), 5);
            end
        end
`ifndef MEM_ARB_RR_EN
        checkOutput("sim_ldr_starved", 32'(lacks), 0);
`endif
    endtask

    task automatic testResetInWait();
        int ack_cnt = 0;
        int ack_k = -1;
        nextDrive();
        applyStimulus(PORT_CPU, 1'b1, 1'b0, 32'h20, 32'hCAFE0001);
        repeat (2) @(negedge Clk);
        #2 reset = 1'b1;
        #1;
        checkOutput("rstw_cpu_ack", 32'(cpu_ack), 0);
        checkOutput("rstw_mem_en", 32'(mem_en), 0);
        checkOutput("rstw_mem_we", 32'(mem_we), 0);
        checkOutput("rstw_rd_data", rd_data, 0);
        checkOutput("rstw_mem_addr", mem_addr, 0);
        checkOutput("rstw_mem_wdata", mem_wdata, 0);
        cpu_req = 1'b0;
        repeat (2) @(negedge Clk);
        #2 reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge Clk);
            ack_cnt += int'(cpu_ack) + int'(ldr_ack);
        end
        checkOutput("rstw_no_ack", 32'(ack_cnt), 0);
        nextDrive();
        applyStimulus(PORT_CPU, 1'b1, 1'b0, 32'h24, 32'h0);
        for (int k = 1; k <= 20; k++) begin
            @(negedge Clk);
            if (cpu_ack) begin
                ack_k = k;
                checkOutput("rstw_new_data", rd_data, dflt(32'h24));
                #1 cpu_req = 1'b0;
                break;
            end
        end
        cpu_req = 1'b0;
        checkOutput("rstw_new_latency", 32'(ack_k), 32'(LAT + 2));
    endtask

    task automatic testLatencySweep();
        int ack_k;
        int exp_k [2] = '{3, 17};
        logic [31:0] a;
        for (int w = 0; w < 2; w++) begin
            ack_k = -1;
            a = 32'h80 + 32'(w * 4);
            nextDrive();
            sw_addr[w] = a;
            sw_req[w] = 1'b1;
            for (int k = 1; k <= 40; k++) begin
                @(negedge Clk);
                if (sw_ack[w]) begin
                    ack_k = k;
                    checkOutput("sweep_data", sw_rd[w], dflt(a));
                    #1 sw_req[w] = 1'b0;
                    break;
                end
            end
            sw_req[w] = 1'b0;
            checkOutput("sweep_ack_cycle", 32'(ack_k), 32'(exp_k[w]));
        end
    endtask

    task automatic randDriver(input logic port, input int cycles);
        logic req_now = 1'b0;
        logic got_ack;
        bit done;
        for (int c = 0; c < cycles; c++) begin
            @(negedge Clk);
            got_ack = (port == PORT_LDR) ? ldr_ack : cpu_ack;
            #1;
            if (req_now && got_ack) begin
                if ($urandom_range(0, 1) == 1) begin
                    applyStimulus(port, 1'b1, 1'($urandom_range(0, 1)), {22'h0, 8'($urandom), 2'b00}, $urandom);
                end else begin
                    applyStimulus(port, 1'b0, 1'b0, 32'h0, 32'h0);
                    req_now = 1'b0;
                end
            end else if (!req_now && $urandom_range(0, 3) == 0) begin
                applyStimulus(port, 1'b1, 1'($urandom_range(0, 1)), {22'h0, 8'($urandom), 2'b00}, $urandom);
                req_now = 1'b1;
            end
        end
        if (req_now) begin
            done = 0;
            for (int c = 0; c < 80 && !done; c++) begin
                @(negedge Clk);
                if ((port == PORT_LDR) ? ldr_ack : cpu_ack) done = 1;
            end
            if (!done) checkOutput("rand_drain_timeout", 0, 1);
            #1 applyStimulus(port, 1'b0, 1'b0, 32'h0, 32'h0);
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main_proc
        chk_on = 1'b0;
        reset = 1'b1;
        applyStimulus(PORT_CPU, 1'b0, 1'b0, 32'h0, 32'h0);
        applyStimulus(PORT_LDR, 1'b0, 1'b0, 32'h0, 32'h0);
        sw_req[0] = 1'b0; sw_req[1] = 1'b0;
        sw_addr[0] = 32'h0; sw_addr[1] = 32'h0;
        repeat (3) @(negedge Clk);
        #2 reset = 1'b0;
        @(negedge Clk);
        checkOutput("rst_rd_data", rd_data, 0);
        checkOutput("rst_mem_addr", mem_addr, 0);
        checkOutput("rst_mem_en", 32'(mem_en), 0);
        checkOutput("rst_acks", {30'h0, cpu_ack, ldr_ack}, 0);
        chk_on = 1'b1;

        testCpuRead();
        settle();
        testLdrWrite();
        settle();
        testBackToBack();
        settle();
        pulseReset();
        settle();
        testSimultaneous();
        settle();
        testResetInWait();
        settle();
        testLatencySweep();
        settle();
        fork
            randDriver(PORT_CPU, 2000);
            randDriver(PORT_LDR, 2000);
        join
        settle();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
